// File: rtl/div_pkg.sv
// Shared types and sizing helpers for the sequential divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold an iteration count of 0..w.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/cla_sub.sv
// N-bit subtractor a - b built from 4-bit carry-lookahead groups, groups chained by carry.
// Combinational; borrow is high when b > a.
module cla_sub #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] diff,
    output logic         borrow
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    // a - b computed as a + ~b + 1
    assign g = a & ~b;
    assign p = a ^ ~b;

    always_comb begin
        logic acc;
        logic pp;
        acc  = 1'b0;
        pp   = 1'b0;
        c    = '0;
        c[0] = 1'b1;
        for (int i = 0; i < N; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= (i / 4) * 4; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & c[(i/4)*4]);
        end
    end

    assign diff   = p ^ c[N-1:0];
    assign borrow = ~c[N];

endmodule

// File: rtl/seq_divider.sv
// Restoring sequential divider, WIDTH iterations (first one on the accepting edge); done pulses one cycle.
// Start is ignored while busy; SEQ_DIVIDER_SIGNED_EN selects two's-complement operands.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic             armed_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dq_q;
    logic [WIDTH-1:0] dvs_q;

    logic             accept;
    logic             dvs_zero;
    logic             last;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH:0]   it_rem;
    logic [WIDTH-1:0] it_dq;
    logic [WIDTH-1:0] it_dvs;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH:0]   nxt_rem;
    logic [WIDTH-1:0] nxt_dq;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] res_r;

    // armed_q keeps the first edge after reset release from accepting a start
    assign accept   = armed_q && start && (state_q != RUN);
    assign dvs_zero = (divisor == '0);
    assign last     = (state_q == RUN) && (cnt_q == CNT_ONE);

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic qneg_q;
    logic rneg_q;

    assign mag_a = dividend[WIDTH-1] ? -dividend : dividend;
    assign mag_b = divisor[WIDTH-1]  ? -divisor  : divisor;
    assign res_q = qneg_q ? -nxt_dq : nxt_dq;
    assign res_r = rneg_q ? -nxt_rem[WIDTH-1:0] : nxt_rem[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (accept) begin
            qneg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            rneg_q <= dividend[WIDTH-1];
        end
    end
`else
    assign mag_a = dividend;
    assign mag_b = divisor;
    assign res_q = nxt_dq;
    assign res_r = nxt_rem[WIDTH-1:0];
`endif

    // On the accepting edge the first iteration runs straight from the inputs
    assign it_rem  = accept ? '0    : rem_q;
    assign it_dq   = accept ? mag_a : dq_q;
    assign it_dvs  = accept ? mag_b : dvs_q;
    assign shifted = {it_rem[WIDTH-1:0], it_dq[WIDTH-1]};

    cla_sub #(.N(WIDTH + 1)) u_sub (
        .a      (shifted),
        .b      ({1'b0, it_dvs}),
        .diff   (diff),
        .borrow (borrow)
    );

    assign nxt_rem = borrow ? shifted : diff;
    assign nxt_dq  = {it_dq[WIDTH-2:0], ~borrow};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    state_d = dvs_zero ? DONE : RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed_q <= 1'b0;
            cnt_q   <= '0;
            rem_q   <= '0;
            dq_q    <= '0;
            dvs_q   <= '0;
        end else begin
            armed_q <= 1'b1;
            if (accept && !dvs_zero) begin
                cnt_q <= CNT_LOAD;
            end else if (state_q == RUN) begin
                cnt_q <= last ? '0 : cnt_q - CNT_ONE;
            end
            if (accept || (state_q == RUN)) begin
                rem_q <= nxt_rem;
                dq_q  <= nxt_dq;
            end
            if (accept) begin
                dvs_q <= mag_b;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept && dvs_zero) begin
            quotient    <= '1;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
        end else if (last) begin
            quotient    <= res_q;
            remainder   <= res_r;
            div_by_zero <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=16); latency k means done seen just before the k-th edge after acceptance.
module tb_seq_divider;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;

    int n_checks = 0;
    int n_errors = 0;

    seq_divider #(.WIDTH(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input bit hold);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic busy1);
        lat   = 0;
        busy1 = 1'b0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk);
            if (k == 1) busy1 = busy;
            if (done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        start = 1'b1; dividend = 16'd100; divisor = 16'd7;
        repeat (2) @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (quotient !== 16'h0) begin n_errors++; $display("FAIL reset_quotient: got %h want 0000", quotient); end
        n_checks++; if (remainder !== 16'h0) begin n_errors++; $display("FAIL reset_remainder: got %h want 0000", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL first_edge_start_ignored: busy %b want 0", busy); end
        start = 1'b0;
    endtask

    task automatic test_basic();
        int lat; logic b1;
        launch(16'd100, 16'd7, 0);
        wait_done(lat, b1);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL basic_latency: got %0d want 16", lat); end
        n_checks++; if (b1 !== 1'b1) begin n_errors++; $display("FAIL basic_busy_run: got %b want 1", b1); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL basic_busy_done: got %b want 0", busy); end
        n_checks++; if (quotient !== 16'd14) begin n_errors++; $display("FAIL basic_quotient: got %0d want 14", quotient); end
        n_checks++; if (remainder !== 16'd2) begin n_errors++; $display("FAIL basic_remainder: got %0d want 2", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL basic_dbz: got %b want 0", div_by_zero); end
        @(negedge clk);
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL basic_done_one_cycle: got %b want 0", done); end
        n_checks++; if (quotient !== 16'd14) begin n_errors++; $display("FAIL basic_hold: got %0d want 14", quotient); end
    endtask

    task automatic test_patterns();
        logic [15:0] va [2];
        logic [15:0] vb [2];
        logic [15:0] vq [2];
        logic [15:0] vr [2];
        int lat; logic b1;
        va = '{16'hFFFF, 16'h0005};
        vb = '{16'h0001, 16'h0009};
        vq = '{16'hFFFF, 16'h0000};
        vr = '{16'h0000, 16'h0005};
        for (int i = 0; i < 2; i++) begin
            launch(va[i], vb[i], 0);
            wait_done(lat, b1);
            n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL pattern%0d_latency: got %0d want 16", i, lat); end
            n_checks++; if (quotient !== vq[i]) begin n_errors++; $display("FAIL pattern%0d_quotient: got %h want %h", i, quotient, vq[i]); end
            n_checks++; if (remainder !== vr[i]) begin n_errors++; $display("FAIL pattern%0d_remainder: got %h want %h", i, remainder, vr[i]); end
        end
    endtask

    task automatic test_div_zero();
        int lat; logic b1;
        launch(16'd1234, 16'd0, 0);
        wait_done(lat, b1);
        n_checks++; if (lat !== 1) begin n_errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
        n_checks++; if (b1 !== 1'b0) begin n_errors++; $display("FAIL dz_busy: got %b want 0", b1); end
        n_checks++; if (quotient !== 16'hFFFF) begin n_errors++; $display("FAIL dz_quotient: got %h want ffff", quotient); end
        n_checks++; if (remainder !== 16'd1234) begin n_errors++; $display("FAIL dz_remainder: got %0d want 1234", remainder); end
        n_checks++; if (div_by_zero !== 1'b1) begin n_errors++; $display("FAIL dz_flag: got %b want 1", div_by_zero); end
        launch(16'd10, 16'd3, 0);
        wait_done(lat, b1);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL after_dz_latency: got %0d want 16", lat); end
        n_checks++; if (quotient !== 16'd3) begin n_errors++; $display("FAIL after_dz_quotient: got %0d want 3", quotient); end
        n_checks++; if (remainder !== 16'd1) begin n_errors++; $display("FAIL after_dz_remainder: got %0d want 1", remainder); end
        n_checks++; if (div_by_zero !== 1'b0) begin n_errors++; $display("FAIL after_dz_flag: got %b want 0", div_by_zero); end
    endtask

    task automatic test_ignore_start();
        int lat; logic b1; int extra;
        launch(16'd100, 16'd7, 0);
        repeat (4) @(negedge clk);
        dividend = 16'd9; divisor = 16'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, b1);
        n_checks++; if (lat !== 11) begin n_errors++; $display("FAIL ignore_latency: got %0d want 11", lat); end
        n_checks++; if (quotient !== 16'd14) begin n_errors++; $display("FAIL ignore_quotient: got %0d want 14", quotient); end
        n_checks++; if (remainder !== 16'd2) begin n_errors++; $display("FAIL ignore_remainder: got %0d want 2", remainder); end
        extra = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) extra++;
        end
        n_checks++; if (extra !== 0) begin n_errors++; $display("FAIL ignore_no_queue: got %0d active cycles want 0", extra); end
    endtask

    task automatic test_back_to_back();
        int lat; logic b1;
        launch(16'd200, 16'd9, 1);
        wait_done(lat, b1);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL b2b_first_latency: got %0d want 16", lat); end
        n_checks++; if (quotient !== 16'd22) begin n_errors++; $display("FAIL b2b_first_quotient: got %0d want 22", quotient); end
        n_checks++; if (remainder !== 16'd2) begin n_errors++; $display("FAIL b2b_first_remainder: got %0d want 2", remainder); end
        dividend = 16'd77; divisor = 16'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat, b1);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL b2b_second_latency: got %0d want 16", lat); end
        n_checks++; if (b1 !== 1'b1) begin n_errors++; $display("FAIL b2b_second_busy: got %b want 1", b1); end
        n_checks++; if (quotient !== 16'd19) begin n_errors++; $display("FAIL b2b_second_quotient: got %0d want 19", quotient); end
        n_checks++; if (remainder !== 16'd1) begin n_errors++; $display("FAIL b2b_second_remainder: got %0d want 1", remainder); end
    endtask

    task automatic test_reset_abort();
        int lat; logic b1; int seen;
        launch(16'd1000, 16'd3, 0);
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        n_checks++; if (quotient !== 16'h0) begin n_errors++; $display("FAIL abort_quotient: got %h want 0000", quotient); end
        n_checks++; if (remainder !== 16'h0) begin n_errors++; $display("FAIL abort_remainder: got %h want 0000", remainder); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done !== 1'b0) seen++;
        end
        n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL abort_no_done: got %0d done cycles want 0", seen); end
        n_checks++; if (quotient !== 16'h0) begin n_errors++; $display("FAIL abort_quotient_after: got %h want 0000", quotient); end
        launch(16'd50, 16'd5, 0);
        wait_done(lat, b1);
        n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL post_abort_latency: got %0d want 16", lat); end
        n_checks++; if (quotient !== 16'd10) begin n_errors++; $display("FAIL post_abort_quotient: got %0d want 10", quotient); end
        n_checks++; if (remainder !== 16'd0) begin n_errors++; $display("FAIL post_abort_remainder: got %0d want 0", remainder); end
    endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
    task automatic test_signed();
        logic [15:0] va [3];
        logic [15:0] vb [3];
        logic [15:0] vq [3];
        logic [15:0] vr [3];
        int lat; logic b1;
        va = '{16'hFFF9, 16'h0007, 16'h8000};
        vb = '{16'h0002, 16'hFFFE, 16'hFFFF};
        vq = '{16'hFFFD, 16'hFFFD, 16'h8000};
        vr = '{16'hFFFF, 16'h0001, 16'h0000};
        for (int i = 0; i < 3; i++) begin
            launch(va[i], vb[i], 0);
            wait_done(lat, b1);
            n_checks++; if (lat !== 16) begin n_errors++; $display("FAIL signed%0d_latency: got %0d want 16", i, lat); end
            n_checks++; if (quotient !== vq[i]) begin n_errors++; $display("FAIL signed%0d_quotient: got %h want %h", i, quotient, vq[i]); end
            n_checks++; if (remainder !== vr[i]) begin n_errors++; $display("FAIL signed%0d_remainder: got %h want %h", i, remainder, vr[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_patterns();
        test_div_zero();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
`ifdef SEQ_DIVIDER_SIGNED_EN
        test_signed();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/result width in bits (legal 4..32).
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request; sampled only when busy is low.
REQ-005 SHALL have port dividend  input  WIDTH  numerator, captured at the accepting edge.
REQ-006 SHALL have port divisor  input  WIDTH  denominator, captured at the accepting edge.
REQ-007 SHALL have port busy  output  1  high while an iteration sequence is running.
REQ-008 SHALL have port done  output  1  one-cycle pulse, results valid.
REQ-009 SHALL have port quotient  output  WIDTH  registered quotient.
REQ-010 SHALL have port remainder  output  WIDTH  registered remainder.
REQ-011 SHALL have port div_by_zero  output  1  registered; set when the completed operation had divisor 0.

Function
REQ-012 SHALL implement states IDLE, RUN, DONE; IDLE->RUN on accepted start with divisor != 0; IDLE->DONE on accepted start with divisor == 0; RUN->DONE after WIDTH iterations; DONE->IDLE otherwise.
REQ-013 SHALL accept start when state is IDLE or DONE (busy low); start in RUN is ignored, with no queuing.
REQ-014 SHALL use a restoring algorithm: per RUN cycle, shift the partial remainder (WIDTH+1 bits) left by one, bringing in the next dividend MSB; trial-subtract divisor; if the result is non-negative, keep it and shift in quotient bit 1, else shift in 0.
REQ-015 SHALL count iterations with a counter of clog2(WIDTH+1) bits, loaded at acceptance and checked for terminal count, with no wrap-around into an extra iteration.
REQ-016 SHALL assert done for exactly one cycle, WIDTH cycles after the accepting edge for a nonzero divisor and 1 cycle after it for divisor 0.
REQ-017 SHALL assert busy exactly while the state is RUN.
REQ-018 SHALL update quotient, remainder and div_by_zero only on entry to DONE and hold them until the next completion.
REQ-019 SHALL, for divisor 0, produce quotient all-ones, remainder = dividend and div_by_zero = 1.
REQ-020 SHALL accept a start in the same cycle as done, without a bubble (back-to-back).

Reset
REQ-021 SHALL, while rst_n is low, force the state to IDLE; busy, done, div_by_zero, quotient and remainder to 0; and the counter to 0.
REQ-022 SHALL treat reset during RUN as an abort: no done pulse; outputs read 0 after release.
REQ-023 SHALL ignore start in the first edge on which rst_n is sampled high.

Configuration
REQ-024 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, treat operands as two's complement: divide magnitudes; negate the quotient if the signs differ; give the remainder the dividend's sign; truncate toward zero.
REQ-025 SHALL, with SEQ_DIVIDER_SIGNED_EN defined, return quotient = most-negative value and remainder = 0 for most-negative / -1; for divisor 0, quotient = all-ones and remainder = dividend.
REQ-026 SHALL, without SEQ_DIVIDER_SIGNED_EN, treat all operands and results as unsigned, with no sign logic present; latency is identical in both builds.

Structure
REQ-027 SHALL take the state enum type and the iteration-counter width function from shared package div_pkg.
REQ-028 SHALL place the WIDTH+1-bit trial subtractor, which returns difference and borrow, in sub-module cla_sub, a carry-lookahead subtract built on the team's CLA group logic.

Verification
REQ-029 SHALL cover: unsigned 100/7, start at edge E -> done at E+16, quotient 14, remainder 2, div_by_zero 0.
REQ-030 SHALL cover: 0xFFFF/0x0001 -> quotient 0xFFFF, remainder 0; 0x0005/0x0009 -> quotient 0, remainder 5.
REQ-031 SHALL cover: 1234/0 -> done at E+1, quotient 0xFFFF, remainder 1234, div_by_zero 1; a following 10/3 -> quotient 3, remainder 1, div_by_zero 0.
REQ-032 SHALL cover: start pulsed during RUN -> ignored, result of the first operation only; start held high during done -> second operation accepted back-to-back, done again 16 cycles later.
REQ-033 SHALL cover: rst_n low at iteration 8 -> no done, all outputs 0, and the next 50/5 -> quotient 10, remainder 0.
REQ-034 SHALL cover, in the signed build: -7/2 -> quotient -3, remainder -1; 7/-2 -> quotient -3, remainder 1; 0x8000/0xFFFF -> quotient 0x8000, remainder 0.
